// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 16x oversampling tick generator. Emits each
// byte on d_out with a one-cycle rx_done, or a one-cycle frame_err when the stop bit is low.
module uart_rx #(
    parameter int DBIT     = 8,
    parameter int SB_TICK  = 16,
    parameter int BAUD_DIV = 163
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    output logic [DBIT-1:0] d_out,
    output logic            rx_done,
    output logic            frame_err,
    output logic [2:0]      fsm_state
);
    // Output protocol: valid-only, no back-pressure. rx_done (or frame_err)
    // is high for exactly one clk; d_out is stable from that cycle until the next rx_done.
    localparam int TW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_HIGH = 3'd4;

    localparam logic [TW-1:0] TCNT_LAST = TW'(BAUD_DIV - 1);
    localparam logic [SW-1:0] S_MID     = SW'(7);
    localparam logic [SW-1:0] S_BIT     = SW'(15);
    localparam logic [SW-1:0] S_STOP    = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);

    logic [2:0]      state;
    logic [TW-1:0]   tcnt;
    logic            tick;
    logic [SW-1:0]   s;
    logic [NW-1:0]   n;
    logic [DBIT-1:0] shreg;
    logic            rx_meta;
    logic            rx_s;

    assign fsm_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Free-running: frame events never realign the tick phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tcnt <= '0;
        else if (tcnt == TCNT_LAST)
            tcnt <= '0;
        else
            tcnt <= tcnt + TW'(1);
    end

    assign tick = (tcnt == TCNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            s         <= '0;
            n         <= '0;
            shreg     <= '0;
            d_out     <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        s     <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (s == S_MID) begin
                            s <= '0;
                            n <= '0;
                            // A line back high at mid start bit was only a glitch.
                            state <= rx_s ? IDLE : DATA;
                        end else begin
                            s <= s + SW'(1);
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (s == S_BIT) begin
                            s     <= '0;
                            shreg <= {rx_s, shreg[DBIT-1:1]};
                            if (n == N_LAST)
                                state <= STOP;
                            else
                                n <= n + NW'(1);
                        end else begin
                            s <= s + SW'(1);
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (s == S_STOP) begin
                            s <= '0;
                            if (rx_s) begin
                                d_out   <= shreg;
                                rx_done <= 1'b1;
                                state   <= IDLE;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= WAIT_HIGH;
                            end
                        end else begin
                            s <= s + SW'(1);
                        end
                    end
                end
                WAIT_HIGH: begin
                    // A break holds the line low; wait it out so no phantom start is seen.
                    if (rx_s)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at BAUD_DIV=4 (one bit = 64 clk); a scoreboard
// queue holds expected {frame_err, rx_done, d_out} events popped by a monitor.
module tb_uart_rx;
    localparam int BIT_CLK = 64;
    localparam logic [2:0] ST_IDLE = 3'd0;

    logic       clk;
    logic       reset;
    logic       rx;
    logic [7:0] d_out;
    logic       rx_done;
    logic       frame_err;
    logic [2:0] fsm_state;

    int compared = 0;
    int failed   = 0;
    logic [9:0] exp_q[$];

    uart_rx #(.DBIT(8), .SB_TICK(16), .BAUD_DIV(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .d_out     (d_out),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .fsm_state (fsm_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Driver tasks
    task automatic hold(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input int bit_clk, input logic stop_val);
        rx = 1'b0;
        hold(bit_clk);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            hold(bit_clk);
        end
        rx = stop_val;
        hold(bit_clk);
    endtask

    task automatic expect_byte(input logic [7:0] data);
        exp_q.push_back({2'b01, data});
    endtask

    task automatic expect_ferr(input logic [7:0] held);
        exp_q.push_back({2'b10, held});
    endtask

    task automatic check(input string name, input logic [9:0] got, input logic [9:0] want);
        compared++;
        if (got !== want) begin
            failed++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!reset && (rx_done || frame_err)) begin
            if (exp_q.size() == 0) begin
                compared++;
                failed++;
                $display("FAIL unexpected_event: got done=%b ferr=%b d_out=%h, required no event",
                         rx_done, frame_err, d_out);
            end else begin
                check("event", {frame_err, rx_done, d_out}, exp_q.pop_front());
            end
        end
    end

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        hold(3);
        check("reset_d_out", {2'b00, d_out}, 10'h000);
        check("reset_strobes", {8'h00, rx_done, frame_err}, 10'h000);
        check("reset_state", {7'h00, fsm_state}, {7'h00, ST_IDLE});
        reset = 1'b0;
        hold(2 * BIT_CLK);

        // 1: single frame
        expect_byte(8'hF0);
        send_frame(8'hF0, BIT_CLK, 1'b1);
        hold(BIT_CLK);

        // 2: back-to-back frames, no idle gap
        expect_byte(8'h55);
        expect_byte(8'hAA);
        send_frame(8'h55, BIT_CLK, 1'b1);
        send_frame(8'hAA, BIT_CLK, 1'b1);
        hold(BIT_CLK);

        // 3: short start glitch (3 ticks)
        rx = 1'b0;
        hold(12);
        rx = 1'b1;
        hold(2 * BIT_CLK);
        check("glitch_d_out", {2'b00, d_out}, {2'b00, 8'hAA});
        check("glitch_state", {7'h00, fsm_state}, {7'h00, ST_IDLE});

        // 4: framing error followed by a long break, then a good frame
        expect_ferr(8'hAA);
        send_frame(8'h3C, BIT_CLK, 1'b0);
        hold(20 * BIT_CLK);
        rx = 1'b1;
        hold(2 * BIT_CLK);
        check("break_d_out", {2'b00, d_out}, {2'b00, 8'hAA});
        expect_byte(8'h81);
        send_frame(8'h81, BIT_CLK, 1'b1);
        hold(BIT_CLK);

        // 5: reset during data bit 4 of 0xA5, then a clean 0x5A
        rx = 1'b0;
        hold(BIT_CLK);
        for (int i = 0; i < 4; i++) begin
            rx = (i == 0 || i == 2);
            hold(BIT_CLK);
        end
        rx = 1'b0;
        hold(BIT_CLK / 2);
        reset = 1'b1;
        hold(1);
        check("midreset_d_out", {2'b00, d_out}, 10'h000);
        check("midreset_state", {7'h00, fsm_state}, {7'h00, ST_IDLE});
        hold(2);
        rx = 1'b1;
        reset = 1'b0;
        hold(2 * BIT_CLK);
        expect_byte(8'h5A);
        send_frame(8'h5A, BIT_CLK, 1'b1);
        hold(BIT_CLK);

        // 6: +3% baud skew
        expect_byte(8'hC3);
        send_frame(8'hC3, 66, 1'b1);
        hold(2 * BIT_CLK);

        for (int i = 0; i < 2000 && exp_q.size() != 0; i++)
            @(negedge clk);
        check("queue_drained", 10'(exp_q.size()), 10'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule
